// File: rtl/shift_mix_stage_if.sv
// Valid/ready bus for shift_mix_stage: SubBytes state in, ShiftRows/MixColumns state out.
// master drives s_in/in_valid/in_last/out_ready; slave (the stage) drives the rest.
interface shift_mix_stage_if #(
    parameter int CNT_W = 16
);
    logic [127:0]     s_in;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [127:0]     m_o;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic [CNT_W-1:0] blk_cnt;

    modport master (
        output s_in, in_valid, in_last, out_ready,
        input  in_ready, m_o, out_valid, out_last, blk_cnt
    );

    modport slave (
        input  s_in, in_valid, in_last, out_ready,
        output in_ready, m_o, out_valid, out_last, blk_cnt
    );
endinterface

// File: rtl/shift_mix_stage.sv
// AES round stage: ShiftRows then MixColumns (skipped when in_last), registered,
// valid/ready handshaked, one block per cycle, with a delivered-block counter.
// Ports: clk, rst (async, active-high), bus (shift_mix_stage_if.slave):
//   s_in/in_valid/in_last/in_ready in, m_o/out_valid/out_last/out_ready out,
//   blk_cnt = blocks delivered since reset (wraps silently).
// Byte 0 = bits [127:120]; column c = bytes 4c..4c+3, row r = byte 4c+r.
// Build option: MIXCOL_PIPE_EN adds a register between ShiftRows and
// MixColumns (latency 2, up to 2 blocks in flight); default latency is 1.
module shift_mix_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    shift_mix_stage_if.slave bus
);

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // 3a = xtime(a) ^ a
    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    logic [127:0]     sr;
    logic             in_fire;
    logic             out_fire;
    logic [127:0]     m_q, m_d;
    logic             last_q, last_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sr       = shift_rows(bus.s_in);
    assign out_fire = vld_q && bus.out_ready;
    assign in_fire  = bus.in_valid && bus.in_ready;

`ifdef MIXCOL_PIPE_EN
    logic [127:0] s1_q, s1_d;
    logic         s1_last_q, s1_last_d;
    logic         s1_vld_q, s1_vld_d;
    logic         s1_adv;

    // Stage 1 may move into the output register when that is empty or draining.
    assign s1_adv       = !vld_q || bus.out_ready;
    assign bus.in_ready = !s1_vld_q || s1_adv;

    always_comb begin
        s1_d      = s1_q;
        s1_last_d = s1_last_q;
        s1_vld_d  = s1_vld_q;
        m_d       = m_q;
        last_d    = last_q;
        vld_d     = vld_q;
        if (s1_adv) begin
            vld_d = s1_vld_q;
            if (s1_vld_q) begin
                m_d    = s1_last_q ? s1_q : mix_cols(s1_q);
                last_d = s1_last_q;
            end
        end
        if (in_fire) begin
            s1_d      = sr;
            s1_last_d = bus.in_last;
            s1_vld_d  = 1'b1;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s1_last_q <= 1'b0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s1_last_q <= s1_last_d;
            s1_vld_q  <= s1_vld_d;
        end
    end
`else
    assign bus.in_ready = !vld_q || bus.out_ready;

    always_comb begin
        m_d    = m_q;
        last_d = last_q;
        vld_d  = vld_q;
        if (in_fire) begin
            m_d    = bus.in_last ? sr : mix_cols(sr);
            last_d = bus.in_last;
            vld_d  = 1'b1;
        end else if (out_fire) begin
            vld_d = 1'b0;
        end
    end
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (out_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= '0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            m_q    <= m_d;
            last_q <= last_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.m_o       = m_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = vld_q;
    assign bus.blk_cnt   = cnt_q;

endmodule

// File: tb/tb_shift_mix_stage.sv
// Directed-vector bench for shift_mix_stage: reset, final round, MixColumns,
// back-pressure, throughput and asynchronous mid-stream reset.
module tb_shift_mix_stage;

`ifdef MIXCOL_PIPE_EN
    localparam int LAT = 2;
    localparam int CAP = 2;
`else
    localparam int LAT = 1;
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_mix_stage_if #(.CNT_W(16)) bus ();

    shift_mix_stage #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic rdy = 1'b0;

    logic [127:0] src_d[$];
    bit           src_l[$];
    logic [127:0] src_e[$];
    logic [127:0] exp_d[$];
    bit           exp_l[$];
    int           in_cyc[$];
    int           out_cyc[$];

    bit           stall_q = 1'b0;
    logic [127:0] held_m;
    logic         held_l;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s, input bit last);
        logic [7:0]   a[4][4];
        logic [7:0]   t[4][4];
        logic [7:0]   coef[4];
        logic [7:0]   acc;
        logic [127:0] r;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                a[w][c] = s[127-8*(4*c+w) -: 8];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                t[w][c] = a[w][(c+w)%4];
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                if (last) begin
                    acc = t[w][c];
                end else begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++)
                        acc = acc ^ gmul(coef[(k-w+4)%4], t[k][c]);
                end
                r[127-8*(4*c+w) -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic send(input logic [127:0] d, input bit last, input logic [127:0] e);
        src_d.push_back(d);
        src_l.push_back(last);
        src_e.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (src_d.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.s_in     = src_d[0];
            bus.in_last  = src_l[0];
        end else begin
            bus.in_valid = 1'b0;
        end
        bus.out_ready = rdy;
        #1;
        if (stall_q) begin
            check("hold_m", bus.m_o, held_m);
            check("hold_last", 128'(bus.out_last), 128'(held_l));
        end
        stall_q = bus.out_valid && !bus.out_ready;
        held_m  = bus.m_o;
        held_l  = bus.out_last;
        if (bus.out_valid && bus.out_ready) begin
            out_cyc.push_back(cyc);
            if (exp_d.size() == 0) begin
                check("spurious_out", 128'(bus.out_valid), 128'(0));
            end else begin
                check("data", bus.m_o, exp_d.pop_front());
                check("last", 128'(bus.out_last), 128'(exp_l.pop_front()));
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            in_cyc.push_back(cyc);
            exp_d.push_back(src_e.pop_front());
            exp_l.push_back(src_l[0]);
            void'(src_d.pop_front());
            void'(src_l.pop_front());
        end
    endtask

    task automatic drain(input string tag, input int max);
        int k;
        k = 0;
        while ((src_d.size() + exp_d.size()) > 0 && k < max) begin
            step();
            k++;
        end
        if (k >= max)
            check({tag, "_timeout"}, 128'(src_d.size() + exp_d.size()), 128'(0));
    endtask

    task automatic cnt_check(input string tag, input int want);
        step();
        check(tag, 128'(bus.blk_cnt), 128'(want));
    endtask

    initial begin
        logic [127:0] base, d;
        logic [7:0]   kb;

        rst           = 1'b1;
        bus.s_in      = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        base          = 128'h000102030405060708090a0b0c0d0e0f;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_m_o", bus.m_o, 128'(0));
        check("rst_blk_cnt", 128'(bus.blk_cnt), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));

        // final round: ShiftRows only
        rdy = 1'b1;
        in_cyc.delete();
        out_cyc.delete();
        send(128'h00112233445566778899aabbccddeeff, 1'b1,
             128'h0055aaff4499ee3388dd2277cc1166bb);
        drain("final", 20);
        check("final_latency", 128'(out_cyc[0] - in_cyc[0]), 128'(LAT));
        cnt_check("final_cnt", 1);

        // MixColumns: uniform columns make ShiftRows the identity
        send(128'hdb135345f20a225cc6c6c6c601010101, 1'b0,
             ref_model(128'hdb135345f20a225cc6c6c6c601010101, 1'b0));
        send({4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}});
        send({4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}});
        send(base, 1'b1, 128'h00050a0f04090e03080d02070c01060b);
        drain("mix", 30);
        cnt_check("mix_cnt", 5);

        // back-pressure
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            kb = 8'(i * 19 + 1);
            d  = base ^ {16{kb}};
            send(d, 1'(i % 2), ref_model(d, 1'(i % 2)));
        end
        repeat (5) step();
        check("bp_in_ready", 128'(bus.in_ready), 128'(0));
        check("bp_out_valid", 128'(bus.out_valid), 128'(1));
        check("bp_accepted", 128'(4 - src_d.size()), 128'(CAP));
        rdy = 1'b1;
        drain("bp", 30);
        cnt_check("bp_cnt", 9);

        // throughput
        in_cyc.delete();
        out_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            kb = 8'(i * 37 + 5);
            d  = {base[63:0], base[127:64]} ^ {16{kb}};
            send(d, 1'b0, ref_model(d, 1'b0));
        end
        drain("tput", 40);
        check("tput_in_span", 128'(in_cyc[7] - in_cyc[0]), 128'(7));
        check("tput_out_span", 128'(out_cyc[7] - out_cyc[0]), 128'(7));
        check("tput_latency", 128'(out_cyc[0] - in_cyc[0]), 128'(LAT));
        cnt_check("tput_cnt", 17);

        // asynchronous reset while a block waits at the output
        rdy = 1'b0;
        send(base, 1'b0, ref_model(base, 1'b0));
        send(~base, 1'b0, ref_model(~base, 1'b0));
        repeat (LAT + 1) step();
        check("mid_pre_valid", 128'(bus.out_valid), 128'(1));
        #2;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("mid_out_valid", 128'(bus.out_valid), 128'(0));
        check("mid_blk_cnt", 128'(bus.blk_cnt), 128'(0));
        check("mid_m_o", bus.m_o, 128'(0));
        src_d.delete();
        src_l.delete();
        src_e.delete();
        exp_d.delete();
        exp_l.delete();
        stall_q = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdy = 1'b1;
        d   = 128'h3243f6a8885a308d313198a2e0370734;
        send(d, 1'b0, ref_model(d, 1'b0));
        drain("post", 20);
        cnt_check("post_cnt", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
